// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-memory (OAM) DMA controller. A CPU write to TRIG_ADDR latches a
// source page and halts the CPU. The controller then copies 256 bytes from
// {page, 8'h00}..{page, 8'hFF} to the OAM data port, one READ/WRITE bus-cycle
// pair per byte, and releases the CPU when the last byte has been written.
//
// The CPU can only be stopped on a read cycle, so the controller waits in
// HALT while the CPU keeps writing. Bus reads must fall on even cycles of a
// free-running parity bit; if the HALT exit lands on the wrong parity, one
// dummy ALIGN read cycle is inserted.
//
// Ports
//   clk_ph1     in   1   sole clock, rising-edge
//   rst         in   1   synchronous reset, active low
//   cpu_addr    in  16   CPU address bus
//   cpu_dout    in   8   CPU write data (source page on a trigger write)
//   cpu_rw      in   1   CPU direction, 1 = read, 0 = write
//   bus_din     in   8   shared data bus value during DMA read cycles
//   rdy         out  1   CPU ready, 0 halts the CPU
//   dma_active  out  1   bus mux select, 1 = DMA drives address/data bus
//   dma_addr    out 16   DMA address
//   dma_dout    out  8   DMA write data
//   dma_rw      out  1   DMA direction, 1 = read, 0 = write
//   dbg_state   out  3   current FSM state (state_t encoding), for debug
//
// Parameters
//   TRIG_ADDR   DMA trigger register address
//   OAM_ADDR    sprite data port address written on every WRITE cycle
//
// Every output is a flop. Output flops are loaded from the *next* state, so
// the value seen during a cycle always describes the state of that cycle.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_dout,
    output logic        dma_rw,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        par_q;             // free-running cycle parity
    logic [7:0]  page_q, page_d;    // source page (high address byte)
    logic [7:0]  idx_q,  idx_d;     // byte index within the page
    logic [7:0]  buf_q,  buf_d;     // byte fetched by the last READ

    // Next values for the registered outputs
    logic        rdy_d;
    logic        act_d;
    logic [15:0] addr_d;
    logic [7:0]  dout_d;
    logic        rw_d;

    // Output flops
    logic        rdy_q;
    logic        act_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q;
    logic        rw_q;

    logic        trig_hit;

    // Only a CPU write to the trigger register starts a transfer.
    assign trig_hit = (cpu_addr == TRIG_ADDR) && !cpu_rw;

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;

        case (state_q)
            S_IDLE: begin
                if (trig_hit) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end

            S_HALT: begin
                // The CPU only stops on a read cycle. par toggles every
                // cycle, so the next cycle has par=0 exactly when par_q=1;
                // otherwise burn one ALIGN cycle to land READ on par=0.
                if (cpu_rw) begin
                    state_d = par_q ? S_READ : S_ALIGN;
                end
            end

            S_ALIGN: begin
                // Dummy read; whatever is on the bus is ignored.
                state_d = S_READ;
            end

            S_READ: begin
                buf_d   = bus_din;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs decoded from the state being entered, so that after the
        // clock edge they match the state the FSM is actually in.
        rdy_d  = 1'b1;
        act_d  = 1'b0;
        addr_d = 16'h0000;
        dout_d = 8'h00;
        rw_d   = 1'b1;

        case (state_d)
            S_HALT: begin
                rdy_d = 1'b0;
            end

            S_ALIGN, S_READ: begin
                rdy_d  = 1'b0;
                act_d  = 1'b1;
                addr_d = {page_d, idx_d};
            end

            S_WRITE: begin
                // buf_d already holds the byte captured at the end of READ.
                rdy_d  = 1'b0;
                act_d  = 1'b1;
                addr_d = OAM_ADDR;
                dout_d = buf_d;
                rw_d   = 1'b0;
            end

            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q <= S_IDLE;
            par_q   <= 1'b0;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            buf_q   <= 8'h00;
            rdy_q   <= 1'b1;
            act_q   <= 1'b0;
            addr_q  <= 16'h0000;
            dout_q  <= 8'h00;
            rw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            par_q   <= ~par_q;
            page_q  <= page_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            rdy_q   <= rdy_d;
            act_q   <= act_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rw_q    <= rw_d;
        end
    end

    assign rdy        = rdy_q;
    assign dma_active = act_q;
    assign dma_addr   = addr_q;
    assign dma_dout   = dout_q;
    assign dma_rw     = rw_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Bench for oam_dma_ctrl. A transfer-level model tracks idle / halted /
// transferring plus a step counter and derives every expected output of the
// current cycle arithmetically from that step number. A write-data
// scoreboard holds the 256 bytes each accepted trigger must deliver.
// Directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw;
  logic [2:0]  dbg_state;

  always #5 clk_ph1 = ~clk_ph1;

  oam_dma_ctrl dut (
    .clk_ph1    (clk_ph1),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_rw     (cpu_rw),
    .bus_din    (bus_din),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_rw     (dma_rw),
    .dbg_state  (dbg_state)
  );

  // Memory model: page 02 holds n ^ A5, other pages a simple hash.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5C;
  endfunction

  assign bus_din = mem_byte(dma_addr);

  // -------------------------------------------------------------------------
  // Counters and check helper
  // -------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transfer-level model, advanced on each rising edge
  //   m_mode 0 = idle, 1 = halted waiting for CPU read, 2 = transferring
  //   cyc counts edges since the last reset edge; its LSB is the parity
  //   m_n is the bus-cycle number within the transfer
  // -------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         m_mode = 0;
  int         m_n = 0;
  int         m_total = 0;
  int         cyc = 0;
  bit         m_align = 1'b0;
  logic [7:0] m_page = 8'h00;
  bit         started = 1'b0;

  always @(posedge clk_ph1) begin
    if (!rst) begin
      m_mode  = 0;
      m_page  = 8'h00;
      cyc     = 0;
      started = 1'b1;
      exp_q.delete();
    end else begin
      cyc++;
      case (m_mode)
        0: if (cpu_addr == 16'h4014 && !cpu_rw) begin
             m_page = cpu_dout;
             m_mode = 1;
             for (int k = 0; k < 256; k++) exp_q.push_back(mem_byte({m_page, 8'(k)}));
           end
        1: if (cpu_rw) begin
             // first bus cycle must be a read on even parity, else one dummy read
             m_align = (cyc % 2) != 0;
             m_total = 512 + int'(m_align);
             m_n     = 0;
             m_mode  = 2;
           end
        default: begin
             m_n++;
             if (m_n == m_total) m_mode = 0;
           end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Compare process: every cycle, away from the active edge
  // -------------------------------------------------------------------------
  always @(negedge clk_ph1) begin
    logic        e_rdy, e_act, e_rw, chk_dout;
    logic [15:0] e_addr;
    logic [7:0]  e_dout, w_exp;
    int          j;
    if (started) begin
      e_rdy = (m_mode == 0);
      e_act = (m_mode == 2);
      e_addr = 16'h0000; e_rw = 1'b1; e_dout = 8'h00; chk_dout = 1'b1;
      if (m_mode == 2) begin
        j = m_n - int'(m_align);
        if (m_align && m_n == 0) begin
          e_addr = {m_page, 8'h00}; chk_dout = 1'b0;
        end else if (j % 2 == 0) begin
          e_addr = {m_page, 8'(j / 2)}; chk_dout = 1'b0;
        end else begin
          e_addr = 16'h2004; e_rw = 1'b0; e_dout = mem_byte({m_page, 8'(j / 2)});
        end
      end
      check("rdy", {15'd0, rdy}, {15'd0, e_rdy});
      check("dma_active", {15'd0, dma_active}, {15'd0, e_act});
      check("dma_addr", dma_addr, e_addr);
      check("dma_rw", {15'd0, dma_rw}, {15'd0, e_rw});
      if (chk_dout) check("dma_dout", {8'd0, dma_dout}, {8'd0, e_dout});
      if (dma_active && !dma_rw) begin
        if (exp_q.size() == 0) begin
          check("wdata_underflow", 16'd1, 16'd0);
        end else begin
          w_exp = exp_q.pop_front();
          check("wdata_sb", {8'd0, dma_dout}, {8'd0, w_exp});
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  logic [7:0]  wq[$];
  logic [15:0] first_addr, last_rd_addr;
  int          low_cnt, wr_cnt;
  bit          seen_513, seen_514;

  task automatic tick();
    @(negedge clk_ph1);
    #1;
  endtask

  task automatic noise();
    tick();
    cpu_addr = 16'($urandom_range(0, 65535));
    cpu_rw   = 1'($urandom_range(0, 1));
    cpu_dout = 8'($urandom_range(0, 255));
    if (cpu_addr == 16'h4014 && !cpu_rw) cpu_addr = 16'h4015;
  endtask

  task automatic trigger(input logic [7:0] page);
    tick();
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_dout = page;
  endtask

  // Runs one transfer to completion; stall = HALT cycles with cpu_rw held 0,
  // poke = issue a trigger-register write while the transfer is running.
  task automatic wait_done(input int stall, input bit poke);
    bit done;
    done = 1'b0;
    low_cnt = 0; wr_cnt = 0; wq.delete();
    first_addr = 16'hFFFF; last_rd_addr = 16'hFFFF;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (c < stall) begin
        cpu_rw = 1'b0; cpu_addr = 16'h0100; cpu_dout = 8'h11;
        check("halt_stall", {14'd0, rdy, dma_active}, 16'd0);
      end else if (poke && c == stall + 20) begin
        cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_dout = 8'h77;
      end else begin
        cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_dout = 8'h00;
      end
      if (!rdy) low_cnt++;
      if (dma_active && first_addr == 16'hFFFF) first_addr = dma_addr;
      if (dma_active && dma_rw) last_rd_addr = dma_addr;
      if (dma_active && !dma_rw) begin wr_cnt++; wq.push_back(dma_dout); end
      if (rdy && c > 0) done = 1'b1;
    end
    if (!done) check("transfer_timeout", 16'd1, 16'd0);
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin
    int quiet_bad;

    // Reset: two low edges, then 100 idle cycles with non-trigger traffic
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("reset_rdy", {15'd0, rdy}, 16'd1);
    check("reset_addr", dma_addr, 16'h0000);
    quiet_bad = 0;
    for (int i = 0; i < 100; i++) begin
      noise();
      if (!rdy || dma_active || !dma_rw || dma_addr != 16'h0000) quiet_bad++;
    end
    check("idle_quiet", 16'(quiet_bad), 16'd0);

    // Page 02 transfers at both parities
    seen_513 = 1'b0; seen_514 = 1'b0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < g; k++) begin
        tick(); cpu_rw = 1'b1; cpu_addr = 16'h0000;
      end
      trigger(8'h02);
      wait_done(0, 1'b0);
      if (low_cnt == 513) seen_513 = 1'b1;
      if (low_cnt == 514) seen_514 = 1'b1;
      check("wr_count", 16'(wr_cnt), 16'd256);
      check("first_addr", first_addr, 16'h0200);
      check("last_read", last_rd_addr, 16'h02FF);
      if (wq.size() == 256) begin
        check("wdata_0", {8'd0, wq[0]}, 16'h00A5);
        check("wdata_1", {8'd0, wq[1]}, 16'h00A4);
        check("wdata_2", {8'd0, wq[2]}, 16'h00A7);
        check("wdata_255", {8'd0, wq[255]}, 16'h005A);
      end
    end
    check("rdy_low_513_seen", {15'd0, seen_513}, 16'd1);
    check("rdy_low_514_seen", {15'd0, seen_514}, 16'd1);

    // HALT stall for three cycles
    trigger(8'h05);
    wait_done(3, 1'b0);
    check("stall_wr_count", 16'(wr_cnt), 16'd256);
    check("stall_low_ok", {15'd0, (low_cnt == 516 || low_cnt == 517)}, 16'd1);

    // Reset in the middle of a transfer at idx 40
    trigger(8'h01);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 1000 && !hit; c++) begin
        tick(); cpu_rw = 1'b1; cpu_addr = 16'h8000;
        if (dma_addr == 16'h0140) hit = 1'b1;
      end
      check("reach_0140", {15'd0, hit}, 16'd1);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midreset_rdy", {14'd0, rdy, dma_active}, 16'd2);
    tick(); tick();
    check("midreset_stays_idle", {15'd0, rdy}, 16'd1);
    trigger(8'h03);
    wait_done(0, 1'b0);
    check("restart_first", first_addr, 16'h0300);
    check("restart_wr_count", 16'(wr_cnt), 16'd256);

    // Non-triggers
    tick(); cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_dout = 8'h07;
    tick(); cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h07;
    tick(); cpu_addr = 16'h0000; cpu_rw = 1'b1;
    tick();
    check("nontrig_rdy", {15'd0, rdy}, 16'd1);
    // reset in the same cycle as a trigger write: reset wins
    tick(); rst = 1'b0; cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h09;
    tick(); rst = 1'b1; cpu_addr = 16'h0000; cpu_rw = 1'b1;
    tick();
    check("rst_beats_trig", {15'd0, rdy}, 16'd1);
    // trigger write during an active transfer is ignored
    trigger(8'h04);
    wait_done(0, 1'b1);
    check("poke_first", first_addr, 16'h0400);
    check("poke_last", last_rd_addr, 16'h04FF);
    check("poke_wr_count", 16'(wr_cnt), 16'd256);

    // Random transfers: random gaps, pages, stalls, pokes
    for (int r = 0; r < 6; r++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int k = 0; k < gap; k++) noise();
      trigger(8'($urandom_range(0, 255)));
      wait_done($urandom_range(0, 4), 1'($urandom_range(0, 1)));
      check("rand_wr_count", 16'(wr_cnt), 16'd256);
    end
    tick();
    check("sb_drained", 16'(exp_q.size()), 16'd0);

    // Unconstrained traffic including trigger writes and rare resets
    for (int i = 0; i < 1500; i++) begin
      tick();
      cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom_range(0, 65535));
      cpu_rw   = 1'($urandom_range(0, 1));
      cpu_dout = 8'($urandom_range(0, 255));
      rst      = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
    end
    tick();
    rst = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have ports: clk_ph1  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low (rst=0 resets on clk_ph1 edge).
REQ-003 SHALL have ports: cpu_addr  in  16  CPU address bus; cpu_dout  in  8  CPU write data; cpu_rw  in  1  CPU direction (1=read, 0=write).
REQ-004 SHALL have ports: bus_din  in  8  shared Data_bus read value during DMA read cycles.
REQ-005 SHALL have ports: rdy  out  1  CPU ready (0=halt CPU); dma_active  out  1  bus mux select (1=DMA owns Addr_bus/Data_bus).
REQ-006 SHALL have ports: dma_addr  out  16  DMA address; dma_dout  out  8  DMA write data; dma_rw  out  1  DMA direction (1=read, 0=write).
REQ-007 SHALL have parameters: TRIG_ADDR default 16'h4014, DMA trigger register; OAM_ADDR default 16'h2004, sprite data port.
REQ-008 All outputs SHALL be registered.

Function
REQ-009 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-010 A free-running parity bit par SHALL toggle every clk_ph1 cycle; every READ cycle SHALL occur with par=0.
REQ-011 Trigger: in IDLE, a cycle with cpu_addr==TRIG_ADDR and cpu_rw==0 SHALL latch page<=cpu_dout, idx<=0, next state HALT, rdy<=0.
REQ-012 Reads of TRIG_ADDR, or writes to any other address, SHALL NOT trigger.
REQ-013 HALT: SHALL remain while cpu_rw==0 (CPU cannot stop on a write cycle); dma_active=0.
REQ-014 HALT exit (cpu_rw==1): to READ if the next cycle has par=0, else to ALIGN.
REQ-015 ALIGN: exactly one cycle, dma_active=1, dma_addr={page,idx}, dma_rw=1, read data discarded; then READ.
REQ-016 READ: dma_active=1, dma_addr={page,idx}, dma_rw=1; bus_din SHALL be captured into an 8-bit buffer at cycle end; then WRITE.
REQ-017 WRITE: dma_active=1, dma_addr=OAM_ADDR, dma_dout=buffer, dma_rw=0; idx SHALL increment mod 256.
REQ-018 After the WRITE with idx==8'hFF: next state IDLE, rdy=1, dma_active=0; idx wraps to 0, page unchanged.
REQ-019 Transfer length SHALL be exactly 256 READ/WRITE pairs: 512 bus cycles, plus 1 if ALIGN taken, plus HALT cycles.
REQ-020 In IDLE/HALT: dma_addr=16'h0000, dma_dout=8'h00, dma_rw=1.
REQ-021 Trigger-address writes while not IDLE SHALL be ignored; no restart, page unchanged.
REQ-022 rdy SHALL be 0 in every non-IDLE state and 1 in IDLE.

Reset
REQ-023 rst=0 at a clk_ph1 edge SHALL force IDLE, par=0, page=0, idx=0, buffer=0, rdy=1, dma_active=0, dma_addr=0, dma_dout=0, dma_rw=1, regardless of state (including mid-transfer).
REQ-024 After reset release, SHALL be idle until a fresh trigger; no partial transfer resumes.
REQ-025 rst asserted in the same cycle as a trigger write: reset SHALL win, no trigger.

Verification
REQ-026 Reset: rst=0 two cycles, then 1 -> rdy=1, dma_active=0, dma_rw=1, dma_addr=0000, no activity for 100 cycles.
REQ-027 Trigger: write 8'h02 to 4014, cpu_rw=1 afterward -> dma_addr sequence 0200,2004,0201,2004,...,02FF,2004; rdy low for 1+512 or 1+513 cycles depending on par; every READ has par=0.
REQ-028 Data: memory model page 02 returns byte n = n XOR 8'hA5 -> 256 WRITE cycles to 2004 with dma_dout = A5,A4,A7,...,5A in order.
REQ-029 HALT stall: hold cpu_rw=0 three cycles after trigger -> stays HALT, dma_active=0, rdy=0 for those cycles; transfer starts after cpu_rw=1.
REQ-030 Reset mid-transfer at idx=8'h40 -> next cycle IDLE, rdy=1; new trigger with 8'h03 restarts at 0300.
REQ-031 Non-triggers: read of 4014, write to 4015, write to 4014 during active DMA -> no state change, page unchanged.
